// File: rtl/analog_probe_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// analog_probe_pkg
// Shared types and constants for the analog probe scheduler.
//   probe_kind_e  : which quantity a requester wants fetched (voltage/current)
//   sched_state_e : sequencer states, IDLE -> SETUP -> FIRE -> WAIT ->
//                   CAPTURE -> RESP -> IDLE
//   PROBE_VALUE_W : width of a probe result (IEEE-754 double bit pattern)
// ---------------------------------------------------------------------------
package analog_probe_pkg;

  localparam int PROBE_VALUE_W = 64;

  typedef enum logic {
    PROBE_V = 1'b0,
    PROBE_I = 1'b1
  } probe_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_FIRE    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESP    = 3'd5
  } sched_state_e;

endpackage

// File: rtl/analog_probe_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: returns the first asserted request
// at or after ptr, wrapping around NUM_REQ.
//   req       in  NUM_REQ  request vector
//   ptr       in  IDX_W    highest-priority index for this pick
//   grant     out NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx out IDX_W    encoded winner index (0 when no request)
//   grant_any out 1        at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Scan offsets from farthest to nearest so the nearest hit (the one closest
  // to ptr) is the last assignment and therefore wins.
  always_comb begin
    int cand;
    cand      = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (req[cand]) begin
        grant_idx = IDX_W'(cand);
        grant_any = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign grant[gi] = grant_any && (grant_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/analog_probe_scheduler.sv
// ---------------------------------------------------------------------------
// analog_probe_scheduler
// Shares a single analog probe between NUM_REQ requesters. A round-robin
// winner is granted in IDLE, its node is presented to the probe for a full
// cycle, the voltage or current toggle is flipped once, the result is
// captured SETTLE_CYCLES later and handed back with a valid/ready response.
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/kind/node        per-requester request (node packed by index)
//   req_ready                  one-hot accept, combinational, IDLE only
//   rsp_valid/ready            response handshake
//   rsp_id/value/err           winner index, captured bits, invalid-node flag
//   probe_node                 node select to the probe
//   probe_v/i_toggle           fetch triggers, any edge starts a fetch
//   probe_value/node_ok        probe result and its validity
//   busy                       sequencer not in IDLE
// ---------------------------------------------------------------------------
module analog_probe_scheduler
  import analog_probe_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int NODE_IDX_W    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_kind,
  input  logic [NUM_REQ*NODE_IDX_W-1:0] req_node,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [PROBE_VALUE_W-1:0]      rsp_value,
  output logic                          rsp_err,
  output logic [NODE_IDX_W-1:0]         probe_node,
  output logic                          probe_v_toggle,
  output logic                          probe_i_toggle,
  input  logic [PROBE_VALUE_W-1:0]      probe_value,
  input  logic                          probe_node_ok,
  output logic                          busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  sched_state_e               state_q, state_d;
  logic [ID_W-1:0]            ptr_q, ptr_d;
  probe_kind_e                kind_q, kind_d;
  logic [ID_W-1:0]            id_q, id_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       v_tog_q, v_tog_d;
  logic                       i_tog_q, i_tog_d;
  logic [NODE_IDX_W-1:0]      probe_node_q, probe_node_d;
  logic [PROBE_VALUE_W-1:0]   rsp_value_q, rsp_value_d;
  logic                       rsp_err_q, rsp_err_d;
  logic [ID_W-1:0]            rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0]         grant;
  logic [ID_W-1:0]            grant_idx;
  logic                       grant_any;
  logic [NODE_IDX_W-1:0]      node_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_node_unpack
      assign node_arr[gi] = req_node[gi*NODE_IDX_W +: NODE_IDX_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      kind_q       <= PROBE_V;
      id_q         <= '0;
      cnt_q        <= '0;
      v_tog_q      <= 1'b0;
      i_tog_q      <= 1'b0;
      probe_node_q <= '0;
      rsp_value_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      kind_q       <= kind_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      v_tog_q      <= v_tog_d;
      i_tog_q      <= i_tog_d;
      probe_node_q <= probe_node_d;
      rsp_value_q  <= rsp_value_d;
      rsp_err_q    <= rsp_err_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (grant_any) state_d = ST_SETUP;
      ST_SETUP:   state_d = ST_FIRE;
      ST_FIRE:    state_d = ST_WAIT;
      // Counter enters WAIT at SETTLE_CYCLES, so WAIT lasts that many cycles.
      ST_WAIT:    if (cnt_q <= CNT_W'(1)) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    ptr_d        = ptr_q;
    kind_d       = kind_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    v_tog_d      = v_tog_q;
    i_tog_d      = i_tog_q;
    probe_node_d = probe_node_q;
    rsp_value_d  = rsp_value_q;
    rsp_err_d    = rsp_err_q;
    rsp_id_d     = rsp_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          kind_d       = probe_kind_e'(req_kind[grant_idx]);
          id_d         = grant_idx;
          // probe_node doubles as the latched node; loading it at grant
          // means it is stable through the whole SETUP cycle.
          probe_node_d = node_arr[grant_idx];
          ptr_d        = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                           : grant_idx + ID_W'(1);
        end
      end
      ST_FIRE: begin
        if (kind_q == PROBE_V) v_tog_d = ~v_tog_q;
        else                   i_tog_d = ~i_tog_q;
        cnt_d = CNT_W'(SETTLE_CYCLES);
      end
      ST_WAIT: begin
        if (cnt_q > CNT_W'(1)) cnt_d = cnt_q - CNT_W'(1);
      end
      ST_CAPTURE: begin
        rsp_value_d = probe_node_ok ? probe_value : '0;
        rsp_err_d   = ~probe_node_ok;
        rsp_id_d    = id_q;
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    req_ready      = (state_q == ST_IDLE) ? grant : '0;
    rsp_valid      = (state_q == ST_RESP);
    busy           = (state_q != ST_IDLE);
    rsp_id         = rsp_id_q;
    rsp_value      = rsp_value_q;
    rsp_err        = rsp_err_q;
    probe_node     = probe_node_q;
    probe_v_toggle = v_tog_q;
    probe_i_toggle = i_tog_q;
  end

endmodule
